// File: rtl/shift_pkg.sv
// shift_pkg: shared widths, shift type and FSM state encodings for the sequential shifter.
package shift_pkg;
   localparam int DATA_W = 16;
   localparam int AMT_W = $clog2(DATA_W);
   typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_type_e;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
endpackage

// File: rtl/shift_step.sv
// shift_step: one combinational shift/rotate step of 1 or 4 positions, with the last bit out as carry.
module shift_step
   import shift_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   input  shift_type_e       ty,
   input  logic              step4,
   output logic [DATA_W-1:0] next_data,
   output logic              c
);
   logic       lsl;
   logic       fill1;
   logic [3:0] fill4;
   assign lsl = ty == SH_LSL;
   // right shifts differ only in what enters from the top
   assign fill1 = ty == SH_ASR ? data[DATA_W-1] : ty == SH_ROR ? data[0] : 1'b0;
   assign fill4 = ty == SH_ASR ? {4{data[DATA_W-1]}} : ty == SH_ROR ? data[3:0] : 4'b0;
   assign next_data = lsl ? (step4 ? {data[DATA_W-5:0], 4'b0} : {data[DATA_W-2:0], 1'b0})
                          : (step4 ? {fill4, data[DATA_W-1:4]} : {fill1, data[DATA_W-1:1]});
   assign c = lsl ? (step4 ? data[DATA_W-4] : data[DATA_W-1]) : (step4 ? data[3] : data[0]);
endmodule

// File: rtl/shift_seq_unit.sv
// shift_seq_unit: multi-cycle shift/rotate unit with valid/ready request and response.
// SHIFT_STEP4_EN: take 4-position steps while at least 4 positions remain.
module shift_seq_unit
   import shift_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_data,
   input  logic [AMT_W-1:0]  req_amount,
   input  logic [1:0]        req_type,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_c
);
   state_e            state;
   shift_type_e       ty;
   logic [DATA_W-1:0] d;
   logic [DATA_W-1:0] nd;
   logic [AMT_W-1:0]  cnt;
   logic [AMT_W-1:0]  dec;
   logic              nc;
   logic              step4;
`ifdef SHIFT_STEP4_EN
   assign step4 = cnt >= AMT_W'(4);
`else
   assign step4 = 1'b0;
`endif
   assign dec = step4 ? AMT_W'(4) : AMT_W'(1);
   assign req_ready = state == ST_IDLE;
   shift_step u_step (
      .data      (d),
      .ty        (ty),
      .step4     (step4),
      .next_data (nd),
      .c         (nc)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= ST_IDLE;
         ty <= SH_LSL;
         d <= '0;
         cnt <= '0;
         rsp_valid <= 1'b0;
         rsp_data <= '0;
         rsp_c <= 1'b0;
      end else
         case (state)
            ST_IDLE:
               if (req_valid) begin
                  ty <= shift_type_e'(req_type);
                  d <= req_data;
                  cnt <= req_amount;
                  if (req_amount == '0) begin
                     state <= ST_DONE;
                     rsp_valid <= 1'b1;
                     rsp_data <= req_data;
                     rsp_c <= 1'b0;
                  end else
                     state <= ST_SHIFT;
               end
            ST_SHIFT: begin
               d <= nd;
               cnt <= cnt - dec;
               if (cnt == dec) begin
                  state <= ST_DONE;
                  rsp_valid <= 1'b1;
                  rsp_data <= nd;
                  rsp_c <= nc;
               end
            end
            ST_DONE:
               if (rsp_ready) begin
                  state <= ST_IDLE;
                  rsp_valid <= 1'b0;
               end
            default: state <= ST_IDLE;
         endcase
endmodule
